// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding, state decode and counter sizing helpers.
package serial_adder_ctrl_pkg;

  // FSM state encoding; 2'd3 is never entered and decodes to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Map the raw state register onto a legal state so that an
  // unreachable encoding behaves exactly like IDLE.
  function automatic logic [1:0] decode_state(input logic [1:0] st);
    logic [1:0] res;
    case (st)
      ST_IDLE: res = ST_IDLE;
      ST_RUN:  res = ST_RUN;
      ST_DONE: res = ST_DONE;
      default: res = ST_IDLE;
    endcase
    return res;
  endfunction

  // Bit counter width: enough to index WIDTH bits, never narrower than 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_from_ha.sv
// 1-bit full adder assembled from two half adders and an OR gate.
// The first half adder combines the operand bits, the second folds in the
// carry-in; at most one of the two partial carries can be set, so OR-ing
// them yields the full-adder carry-out.
module fa_from_ha (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  halfadder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  halfadder u_ha1 (
    .a (s1),
    .b (ci),
    .s (s),
    .c (c2)
  );

  assign co = c1 | c2;

endmodule

// File: rtl/halfadder.sv
// 1-bit half adder cell: sum is the XOR, carry is the AND of the inputs.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller. A single full-adder cell is
// time-shared across the operand bits, LSB first, one bit per clock.
// Operands are taken with a valid/ready handshake in IDLE, processed over
// WIDTH cycles in RUN, and the result is presented in DONE until the
// consumer accepts it.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // FSM state (raw register and its legalised decode)
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [1:0]       cur_state;

  // Operand and result shift registers, running carry and bit counter
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  // Registered outputs, captured on the final bit so they stay frozen in DONE
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  // Full-adder cell outputs for the current bit
  logic             fa_s;
  logic             fa_co;

  logic             accept;
  logic             last_bit;

  assign cur_state = decode_state(state_reg);
  assign accept    = (cur_state == ST_IDLE) && in_valid;
  assign last_bit  = (cur_state == ST_RUN) && (cnt_reg == CNT_LAST);

  // Handshake flags come from registered state only.
  assign in_ready  = (cur_state == ST_IDLE);
  assign out_valid = (cur_state == ST_DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

  // The shared adder cell always looks at the LSBs of the shift registers.
  fa_from_ha u_fa (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on the last bit,
  // DONE -> IDLE once the consumer takes the result.
  always_comb begin
    state_next = cur_state;
    case (cur_state)
      ST_IDLE: if (in_valid)  state_next = ST_RUN;
      ST_RUN:  if (last_bit)  state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: load operands on accept, then shift one bit per clock in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      a_sh_reg   <= a;
      b_sh_reg   <= b;
      carry_reg  <= cin;
      cnt_reg    <= '0;
    end else if (cur_state == ST_RUN) begin
      a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
      b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
      res_sh_reg <= {fa_s, res_sh_reg[WIDTH-1:1]};
      carry_reg  <= fa_co;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end

  // Output capture: the full result is known at the last-bit edge, so sum
  // takes the shift register with the final bit already merged in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if (last_bit) begin
      sum_reg  <= {fa_s, res_sh_reg[WIDTH-1:1]};
      cout_reg <= fa_co;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: table-driven adds, hand-written
// back-pressure / reset / back-to-back sequences at WIDTH=8, and an
// exhaustive sweep on a second WIDTH=2 instance. Expected results go into a
// scoreboard queue when operands are driven and are popped on each result.
module tb_serial_adder_ctrl;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;

  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       cin2 = 1'b0;
  logic       out_valid2;
  logic       out_ready2 = 1'b1;
  logic [1:0] sum2;
  logic       cout2;

  int         n_checks = 0;
  int         n_fail = 0;

  logic [8:0] exp_q[$];
  logic [2:0] exp2_q[$];

  vec_t       vecs[8];
  vec_t       pairs[2];

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .cin       (cin2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .sum       (sum2),
    .cout      (cout2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Pop the oldest expectation and compare it with the presented result.
  task automatic pop_check(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_sum"}, {24'd0, sum}, {24'd0, e[7:0]});
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e[8]});
      $display("txn %s: sum=%02h cout=%0d (expected sum=%02h cout=%0d)",
               tag, sum, cout, e[7:0], e[8]);
    end
  endtask

  // One complete add with out_ready already high.
  task automatic do_op(input vec_t v, input string tag);
    int lat;
    out_ready = 1'b1;
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    cin = v.cin;
    exp_q.push_back({v.cout, v.sum});
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
    chk({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, 32'd8);
    pop_check(tag);
    @(negedge clk);
    chk({tag, "_out_valid_pulse"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_back_to_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int got;
    int t;
    int acc[2];
    bit pend;
    logic [4:0] v5;
    int k;
    logic [2:0] e2;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
    pairs[0] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1};
    pairs[1] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sum", {24'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven adds
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure with in_valid / a toggling during RUN and DONE
    out_ready = 1'b0;
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b1;
    exp_q.push_back({1'b1, 8'hFF});
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("bp_in_ready_run", {31'd0, in_ready}, 32'd0);
      in_valid = ~in_valid;
      a = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = 8'($urandom);
      chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready_done", {31'd0, in_ready}, 32'd0);
      chk("bp_result_held", {23'd0, cout, sum}, {23'd0, exp_q[0]});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    pop_check("bp");
    @(negedge clk);
    chk("bp_released", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    a = 8'h55;
    b = 8'hAA;
    cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_busy", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_sum", {24'd0, sum}, 32'd0);
    chk("rst_mid_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op('{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0}, "after_rst");

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    @(negedge clk);
    n = 0;
    got = 0;
    t = 0;
    pend = 1'b0;
    acc[0] = 0;
    acc[1] = 0;
    in_valid = 1'b1;
    a = pairs[0].a;
    b = pairs[0].b;
    cin = pairs[0].cin;
    while ((n < 2 || got < 2) && t < 80) begin
      if (pend) begin
        pend = 1'b0;
        if (n < 2) begin
          a = pairs[n].a;
          b = pairs[n].b;
          cin = pairs[n].cin;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        pop_check("b2b");
        got++;
      end
      if (in_ready && in_valid) begin
        acc[n] = t;
        exp_q.push_back({pairs[n].cout, pairs[n].sum});
        n++;
        pend = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", n, 32'd2);
    chk("b2b_results", got, 32'd2);
    chk("b2b_spacing", acc[1] - acc[0], 32'd10);

    // Exhaustive sweep at WIDTH=2
    for (int i = 0; i < 32; i++) begin
      v5 = 5'(i);
      @(negedge clk);
      k = 0;
      while (!in_ready2 && k < 20) begin
        @(negedge clk);
        k++;
      end
      a2 = v5[4:3];
      b2 = v5[2:1];
      cin2 = v5[0];
      exp2_q.push_back(3'(a2) + 3'(b2) + 3'(cin2));
      in_valid2 = 1'b1;
      @(negedge clk);
      in_valid2 = 1'b0;
      k = 0;
      while (!out_valid2 && k < 20) begin
        @(negedge clk);
        k++;
      end
      e2 = exp2_q.pop_front();
      chk($sformatf("w2_%0d_result", i), {29'd0, out_valid2 ? {cout2, sum2} : 3'bxxx}, {29'd0, e2});
      $display("txn w2: a=%0d b=%0d cin=%0d -> {cout,sum}=%0d (expected %0d)",
               a2, b2, cin2, {cout2, sum2}, e2);
    end

    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
